// File: rtl/nonce_result_reader.sv
// Scans NUM_NONCES consecutive hash words in shared memory. It tracks the minimum word and its
// index, and counts the words that fall below a target. The block only reads memory.
module nonce_result_reader #(
    parameter int unsigned NUM_NONCES = 16,
    parameter int unsigned NONCE_W    = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1,
    parameter int unsigned CNT_W      = $clog2(NUM_NONCES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [15:0]        result_addr,
    input  logic [31:0]        target,
    output logic               done,
    output logic               mem_clk,
    output logic               mem_we,
    output logic [15:0]        mem_addr,
    output logic [31:0]        mem_write_data,
    input  logic [31:0]        mem_read_data,
    output logic [NONCE_W-1:0] best_nonce,
    output logic [31:0]        best_hash,
    output logic               found,
    output logic [CNT_W-1:0]   hit_count
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_NONCES - 1);
    localparam logic [CNT_W-1:0] EndIdx  = CNT_W'(NUM_NONCES);

    typedef enum logic [1:0] {StIdle, StFetch, StRead} state_e;

    state_e             state_q, state_d;
    logic [15:0]        base_q, base_d;
    logic [31:0]        target_q, target_d;
    logic [CNT_W-1:0]   rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]   cap_idx_q, cap_idx_d;
    logic [31:0]        best_hash_q, best_hash_d;
    logic [NONCE_W-1:0] best_nonce_q, best_nonce_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic               found_q, found_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            base_q       <= '0;
            target_q     <= '0;
            rd_idx_q     <= '0;
            cap_idx_q    <= '0;
            best_hash_q  <= '1;
            best_nonce_q <= '0;
            hit_count_q  <= '0;
            found_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            target_q     <= target_d;
            rd_idx_q     <= rd_idx_d;
            cap_idx_q    <= cap_idx_d;
            best_hash_q  <= best_hash_d;
            best_nonce_q <= best_nonce_d;
            hit_count_q  <= hit_count_d;
            found_q      <= found_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        target_d     = target_q;
        rd_idx_d     = rd_idx_q;
        cap_idx_d    = cap_idx_q;
        best_hash_d  = best_hash_q;
        best_nonce_d = best_nonce_q;
        hit_count_d  = hit_count_q;
        found_d      = found_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d       = result_addr;
                    target_d     = target;
                    best_hash_d  = '1;
                    best_nonce_d = '0;
                    hit_count_d  = '0;
                    found_d      = 1'b0;
                    rd_idx_d     = '0;
                    cap_idx_d    = '0;
                    state_d      = StFetch;
                end
            end
            StFetch: begin
                rd_idx_d = rd_idx_q + CNT_W'(1);
                state_d  = StRead;
            end
            StRead: begin
                if (rd_idx_q != EndIdx) begin
                    rd_idx_d = rd_idx_q + CNT_W'(1);
                end
                // Strict compare keeps the lowest index on ties.
                if (mem_read_data < best_hash_q) begin
                    best_hash_d  = mem_read_data;
                    best_nonce_d = cap_idx_q[NONCE_W-1:0];
                end
                if (mem_read_data < target_q) begin
                    hit_count_d = hit_count_q + CNT_W'(1);
                    found_d     = 1'b1;
                end
                if (cap_idx_q == LastIdx) begin
                    state_d = StIdle;
                end else begin
                    cap_idx_d = cap_idx_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Once every word has been requested the last address is held; that read is never captured.
    always_comb begin
        mem_addr = '0;
        unique case (state_q)
            StFetch: mem_addr = base_q;
            StRead: begin
                if (rd_idx_q == EndIdx) begin
                    mem_addr = base_q + 16'(LastIdx);
                end else begin
                    mem_addr = base_q + 16'(rd_idx_q);
                end
            end
            default: mem_addr = '0;
        endcase
    end

    assign done           = (state_q == StIdle);
    assign mem_clk        = clk;
    assign mem_we         = 1'b0;
    assign mem_write_data = '0;
    assign best_nonce     = best_nonce_q;
    assign best_hash      = best_hash_q;
    assign found          = found_q;
    assign hit_count      = hit_count_q;

endmodule
